// File: rtl/gcd_job_dispatch.sv
// Job front/back-end for the 8-bit GCD datapath: tagged operand FIFO, launch FSM,
// local handling of zero operands, timeout abort and a single-entry result slot.
module gcd_job_dispatch #(
    parameter int BusSize        = 8,
    parameter int TAG_W          = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [BusSize-1:0] in_a_i,
    input  logic [BusSize-1:0] in_b_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic [BusSize-1:0] gcd_a_o,
    output logic [BusSize-1:0] gcd_b_o,
    output logic               gcd_go_o,
    input  logic               gcd_done_i,
    input  logic [BusSize-1:0] gcd_result_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BusSize-1:0] out_result_o,
    output logic [TAG_W-1:0]   out_tag_o,
    output logic               out_bypass_o,
    output logic               out_err_o,
    output logic               busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [BusSize-1:0] a;
        logic [BusSize-1:0] b;
        logic [TAG_W-1:0]   tag;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, RUN} state_t;

    job_t               mem [FIFO_DEPTH];
    job_t               head;
    logic [PW:0]        wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    state_t             state, state_d;
    logic [CW-1:0]      timer;
    logic               tmr_clr, tmr_inc, tmr_hit;
    logic [TAG_W-1:0]   job_tag;
    logic               launch, ld_slot, ld_byp, ld_err;
    logic [BusSize-1:0] ld_res;
    logic [TAG_W-1:0]   ld_tag;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;
    assign head       = mem[rd_ptr[PW-1:0]];
    assign gcd_go_o   = (state == ISSUE);
    assign busy_o     = (state != IDLE) || !empty;
    // Abort on the edge the count would reach TIMEOUT_CYCLES-1: slot fills TIMEOUT_CYCLES cycles after ISSUE
    assign tmr_hit    = (timer == CW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{a: in_a_i, b: in_b_i, tag: in_tag_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        launch  = 1'b0;
        ld_slot = 1'b0;
        ld_res  = '0;
        ld_byp  = 1'b0;
        ld_err  = 1'b0;
        ld_tag  = job_tag;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !out_valid_o) begin
                    pop = 1'b1;
                    if (head.a == '0 || head.b == '0) begin
                        ld_slot = 1'b1;
                        ld_res  = head.a | head.b;
                        ld_byp  = 1'b1;
                        ld_tag  = head.tag;
                    end else begin
                        launch  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmr_clr = 1'b1;
                state_d = ACK;
            end
            ACK, RUN: begin
                if (state == RUN && gcd_done_i) begin
                    ld_slot = 1'b1;
                    ld_res  = gcd_result_i;
                    state_d = IDLE;
                end else if (tmr_hit) begin
                    ld_slot = 1'b1;
                    ld_err  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                    if (state == ACK && !gcd_done_i) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            gcd_a_o      <= '0;
            gcd_b_o      <= '0;
            job_tag      <= '0;
            timer        <= '0;
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
            out_tag_o    <= '0;
            out_bypass_o <= 1'b0;
            out_err_o    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (launch) begin
                gcd_a_o <= head.a;
                gcd_b_o <= head.b;
                job_tag <= head.tag;
            end
            if (tmr_clr)      timer <= '0;
            else if (tmr_inc) timer <= timer + CW'(1);
            // Loads only happen with the slot empty, so load and drain never collide
            if (ld_slot) begin
                out_valid_o  <= 1'b1;
                out_result_o <= ld_res;
                out_tag_o    <= ld_tag;
                out_bypass_o <= ld_byp;
                out_err_o    <= ld_err;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gcd_job_dispatch.sv
// Scoreboard bench for gcd_job_dispatch with a behavioural GCD responder.
module tb_gcd_job_dispatch;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, out_ready = 0;
    logic [7:0] in_a = 0, in_b = 0;
    logic [3:0] in_tag = 0;
    logic       in_ready, gcd_go, gcd_done, out_valid, out_bypass, out_err, busy;
    logic [7:0] gcd_a, gcd_b, gcd_res, out_result;
    logic [3:0] out_tag;

    typedef struct {int res; int tag; int byp; int err;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    int cyc = 0, go_cnt = 0, go_cyc = -1, drain_cyc = -1;
    bit stuck = 0, rnd_mode = 0;

    gcd_job_dispatch #(.BusSize(8), .TAG_W(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .gcd_a_o(gcd_a), .gcd_b_o(gcd_b), .gcd_go_o(gcd_go),
        .gcd_done_i(gcd_done), .gcd_result_i(gcd_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_tag_o(out_tag), .out_bypass_o(out_bypass), .out_err_o(out_err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_gcd(int a, int b);
        while (b != 0) begin
            int t;
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // GCD responder: done drops the cycle after go is seen, rises 5 cycles later with the result
    initial begin
        int phase = 0, wcnt = 0, ga = 0, gb = 0;
        gcd_done = 1;
        gcd_res  = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                phase = 0;
                gcd_done = 1;
            end else if (gcd_go) begin
                go_cnt++;
                go_cyc = cyc;
                ga = gcd_a;
                gb = gcd_b;
                phase = 1;
            end else if (stuck) begin
                gcd_done = 1;
            end else if (phase == 1) begin
                gcd_done = 0;
                wcnt = 5;
                phase = 2;
            end else if (phase == 2) begin
                wcnt--;
                if (wcnt == 0) begin
                    gcd_done = 1;
                    gcd_res = 8'(ref_gcd(ga, gb));
                    phase = 0;
                end
            end
        end
    end

    // Monitor: every accepted output is popped from the scoreboard and compared
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            total++;
            drain_cyc = cyc;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got res=%0d tag=%0d with no job pending", out_result, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_result != 8'(e.res) || out_tag != 4'(e.tag) ||
                    out_bypass != e.byp[0] || out_err != e.err[0]) begin
                    bad++;
                    $display("FAIL result: got res=%0d tag=%0d byp=%0b err=%0b want res=%0d tag=%0d byp=%0d err=%0d",
                             out_result, out_tag, out_bypass, out_err, e.res, e.tag, e.byp, e.err);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic push(int a, int b, int tag, int err_exp, output int pcyc);
        bit acc = 0;
        in_valid = 1;
        in_a = 8'(a);
        in_b = 8'(b);
        in_tag = 4'(tag);
        pcyc = -1;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                pcyc = cyc;
                sb.push_back('{(err_exp != 0) ? 0 : ref_gcd(a, b), tag,
                               (a == 0 || b == 0) ? 1 : 0, err_exp});
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(string nm);
        bit ok = 0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(posedge clk); #1;
            ok = !busy && !out_valid && sb.size() == 0;
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic wait_valid(output int vcyc);
        vcyc = -1;
        for (int n = 0; n < 400 && vcyc < 0; n++) begin
            @(posedge clk); #1;
            if (out_valid) vcyc = cyc;
        end
        if (vcyc < 0) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int p, v, g;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_go", gcd_go, 0);
        rst = 0;

        // single GCD job: one go, issued two cycles after the push
        out_ready = 1;
        g = go_cnt;
        push(48, 18, 3, 0, p);
        wait_idle("t1_idle");
        chk("t1_go_count", go_cnt - g, 1);
        chk("t1_go_latency", go_cyc - p, 2);

        // zero operands never reach the GCD; slot valid two cycles after push
        g = go_cnt;
        push(0, 35, 1, 0, p);
        chk("t2_valid_c1", out_valid, 0);
        @(posedge clk); #1;
        chk("t2_valid_c2", out_valid, 1);
        push(0, 0, 2, 0, p);
        wait_idle("t2_idle");
        chk("t2_no_go", go_cnt - g, 0);

        // backpressure: first job sits in the GCD/slot, the next four fill the FIFO
        out_ready = 0;
        push(12, 8, 4, 0, p);
        push(9, 6, 5, 0, p);
        push(7, 7, 6, 0, p);
        push(10, 4, 7, 0, p);
        push(21, 14, 8, 0, p);
        chk("t3_full", in_ready, 0);
        out_ready = 1;
        wait_idle("t3_idle");

        // stuck-done GCD aborts; the queued job then completes normally
        out_ready = 0;
        stuck = 1;
        push(9, 3, 9, 1, p);
        push(8, 12, 10, 0, p);
        wait_valid(v);
        chk("t4_timeout_lat", v - go_cyc, 16);
        stuck = 0;
        out_ready = 1;
        wait_idle("t4_idle");

        // reset while RUN with two jobs queued
        push(20, 8, 11, 0, p);
        push(9, 27, 12, 0, p);
        push(14, 21, 13, 0, p);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_gcd_a", gcd_a, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        push(15, 10, 14, 0, p);
        wait_idle("t5_idle");

        // a full slot holds back the next launch until after it drains
        out_ready = 0;
        push(0, 9, 1, 0, p);
        push(6, 4, 2, 0, p);
        wait_valid(v);
        g = go_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_go_while_full", go_cnt - g, 0);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        for (int n = 0; n < 50 && go_cnt == g; n++) @(posedge clk);
        #1;
        chk("t6_go_seen", go_cnt - g, 1);
        chk("t6_go_after_drain", int'(go_cyc > drain_cyc), 1);
        out_ready = 1;
        wait_idle("t6_idle");

        // random jobs with random consumer backpressure
        rnd_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int a, b;
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            push(a, b, i % 16, 0, p);
        end
        rnd_mode = 0;
        @(posedge clk); #1;
        out_ready = 1;
        wait_idle("rnd_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gcd_job_dispatch.md
Name: gcd_job_dispatch

Overview:
- Front/back-end controller wrapped around the 8-bit GCD datapath (ex02b).
- Accepts tagged operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the GCD with a go pulse, waits for its done, and presents result plus tag on a valid/ready output stream.
- Handles zero operands locally without using the GCD, and flags a GCD that never completes.

Parameters:
- BusSize, 8, operand/result width (matches GCD BusSize).
- TAG_W, 4, job tag width.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 1024, max cycles in ACK+RUN before abort; >=4.

Ports:
- clk_i, input, 1, clock; all logic rising-edge.
- rst_i, input, 1, asynchronous active-high reset.
- in_valid_i, input, 1, operand pair valid.
- in_ready_o, output, 1, FIFO can accept (not full).
- in_a_i, input, BusSize, operand A.
- in_b_i, input, BusSize, operand B.
- in_tag_i, input, TAG_W, job tag.
- gcd_a_o, output, BusSize, to GCD A_in.
- gcd_b_o, output, BusSize, to GCD B_in.
- gcd_go_o, output, 1, to GCD go_in; one-cycle pulse.
- gcd_done_i, input, 1, from GCD Done_out.
- gcd_result_i, input, BusSize, from GCD Output_out.
- out_valid_o, output, 1, result slot full.
- out_ready_i, input, 1, consumer accepts.
- out_result_o, output, BusSize, GCD result.
- out_tag_o, output, TAG_W, tag of the job.
- out_bypass_o, output, 1, result produced locally (zero operand).
- out_err_o, output, 1, timeout abort; result forced 0.
- busy_o, output, 1, FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (async, rst_i=1): FIFO empty, FSM IDLE, all outputs 0 except in_ready_o=1; timeout counter 0. An in-flight job is dropped, no output produced.
- Input push: occurs when in_valid_i && in_ready_o. in_ready_o = !full; no pass-through when full, even if a pop happens in the same cycle.
- Same-cycle push and pop: pop takes the head entry; an entry pushed into an empty FIFO is visible the next cycle.
- FIFO order: strict FIFO; pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- Output slot: single register. out_valid_o holds, with out_result_o/out_tag_o/out_bypass_o/out_err_o stable, until out_valid_o && out_ready_i. On that cycle the slot clears.
- FSM states:
  - IDLE:
    - No action while the FIFO is empty or out_valid_o=1 (a new job never launches in the cycle the slot drains).
    - Otherwise pop the head entry.
    - If A==0 or B==0: load slot next edge with result = A|B (gcd(x,0)=x, gcd(0,0)=0), tag, bypass=1, err=0; stay IDLE.
    - Otherwise register A,B onto gcd_a_o/gcd_b_o and go to ISSUE.
  - ISSUE: gcd_go_o=1 for exactly this cycle; clear timeout counter; go to ACK.
  - ACK: wait for gcd_done_i==0 (GCD acknowledged start, stale done cleared); then go to RUN.
  - RUN: on gcd_done_i==1, capture gcd_result_i into the slot with bypass=0, err=0; go to IDLE.
- Timeout:
  - Counter increments every cycle in ACK or RUN.
  - When it reaches TIMEOUT_CYCLES-1 without completion, load slot with result=0, tag, err=1, bypass=0, and go to IDLE.
  - Completion and timeout in the same cycle: completion wins.
- GCD operand outputs: gcd_a_o/gcd_b_o are held stable from ISSUE until the next launch; they are never changed while in ACK/RUN.
- Latency, idle system:
  - Bypass: push at cycle 0 -> out_valid_o=1 at cycle 2.
  - GCD path: push at cycle 0 -> go at cycle 2 -> out_valid_o one cycle after the done-high sample.
- Throughput: one job in flight; no new go until the slot is empty and the FSM is in IDLE.

Test Plan:
- Push (48,18,tag 3), out_ready_i=1, GCD model: done low 1 cycle after go, high 5 cycles later -> one go pulse; out_result_o=6, tag=3, bypass=0, err=0.
- Push (0,35,tag 1) then (0,0,tag 2) -> gcd_go_o never asserts; outputs 35/tag1 then 0/tag2, both bypass=1; first valid 2 cycles after push.
- out_ready_i=0, push 5 jobs (pairs (12,8),(9,6),(7,7),(10,4),(21,14)) -> in_ready_o low after 4 accepted entries; release ready -> results 4,3,7,2,7 in tag order, no loss or duplication.
- GCD model holds done_i=1 forever, TIMEOUT_CYCLES=16 -> result 0, err=1, exactly 16 cycles after ISSUE; the next queued job then launches normally.
- Assert rst_i mid-RUN with 2 jobs queued -> all outputs 0, in_ready_o=1, busy_o=0 immediately; no stale result after release; a new push (15,10) yields 5.
- Slot full while the FIFO has entries; out_ready_i pulsed for one cycle -> next go occurs no earlier than the cycle after the slot drains.
